muldiv_sequencer: RTL



---
 rtl/muldiv_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Multi-cycle RV32M execution unit (MUL/MULH/MULHSU/MULHU/DIV/
//            DIVU/REM/REMU). Sits beside the EX-stage ALU, stalls the pipe
//            while iterating (shift-add multiply, restoring divide), then
//            presents a registered result for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int                 c_CNT_W    = $clog2(XLEN);
    // The final iteration is folded into FIX, so CALC stops one short.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(XLEN - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [XLEN-1:0]    c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [2:0]            r_op;
    logic                  r_neg;
    logic                  r_done;
    logic [XLEN-1:0]       r_result;
    // Multiplier datapath
    logic [2*XLEN-1:0]     r_prod;
    logic [2*XLEN-1:0]     r_mcand;
    logic [XLEN-1:0]       r_mplier;
    // Divider datapath: r_quo shifts dividend bits out and quotient bits in
    logic [XLEN-1:0]       r_rem;
    logic [XLEN-1:0]       r_quo;
    logic [XLEN-1:0]       r_dvsr;

    // ---------------- operand decode at acceptance ----------------
    logic            w_sgn_a, w_sgn_b, w_neg_a, w_neg_b, w_res_neg;
    logic            w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_res;

    assign w_sgn_a    = (func3 == 3'b001) || (func3 == 3'b010) ||
                        (func3 == 3'b100) || (func3 == 3'b110);
    assign w_sgn_b    = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    assign w_neg_a    = w_sgn_a && rs1[XLEN-1];
    assign w_neg_b    = w_sgn_b && rs2[XLEN-1];
    assign w_mag_a    = w_neg_a ? -rs1 : rs1;
    assign w_mag_b    = w_neg_b ? -rs2 : rs2;
    // Remainder takes the dividend's sign; product and quotient take the XOR.
    assign w_res_neg  = (func3[2] && func3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
    assign w_div_zero = func3[2] && (rs2 == '0);
    assign w_div_ovf  = func3[2] && !func3[0] && (rs1 == c_MIN_NEG) && (rs2 == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    // Result for the division cases that bypass iteration
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = func3[1] ? rs1 : '1;
        end else if (w_div_ovf) begin
            w_special_res = func3[1] ? '0 : c_MIN_NEG;
        end
    end

    // ---------------- one iteration of each datapath ----------------
    logic [2*XLEN-1:0] w_prod_nx, w_prod_fix;
    logic [XLEN:0]     w_dshift;
    logic              w_borrow;
    logic [XLEN-1:0]   w_rem_nx, w_quo_nx, w_rem_fix, w_quo_fix;
    logic [XLEN-1:0]   w_fix_res;

    assign w_prod_nx  = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_dshift   = {r_rem, r_quo[XLEN-1]};
    assign w_borrow   = (w_dshift < {1'b0, r_dvsr});
    // When no borrow the difference fits in XLEN bits, so the low word suffices.
    assign w_rem_nx   = w_borrow ? w_dshift[XLEN-1:0] : (w_dshift[XLEN-1:0] - r_dvsr);
    assign w_quo_nx   = {r_quo[XLEN-2:0], ~w_borrow};

    assign w_prod_fix = r_neg ? -w_prod_nx : w_prod_nx;
    assign w_quo_fix  = r_neg ? -w_quo_nx  : w_quo_nx;
    assign w_rem_fix  = r_neg ? -w_rem_nx  : w_rem_nx;

    // Select the architectural result word for the latched op
    always_comb begin
        w_fix_res = w_prod_fix[XLEN-1:0];
        case (r_op)
            3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo_fix;
            default:                w_fix_res = w_rem_fix;
        endcase
    end

    // Pipeline freeze: accepting cycle plus every iterating cycle, never in reset
    assign stall  = rst_n && !flush &&
                    (((r_state == S_IDLE) && start) || (r_state == S_CALC) || (r_state == S_FIX));
    assign done   = r_done;
    assign result = r_result;

    // Sequencer FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
        end else begin
            r_done <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_op     <= func3;
                            r_neg    <= w_res_neg;
                            r_cnt    <= '0;
                            r_prod   <= '0;
                            r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
                            r_mplier <= w_mag_b;
                            r_rem    <= '0;
                            r_quo    <= w_mag_a;
                            r_dvsr   <= w_mag_b;
                            if (w_special) begin
                                r_result <= w_special_res;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
                                r_state  <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        r_prod   <= w_prod_nx;
                        r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
                        r_rem    <= w_rem_nx;
                        r_quo    <= w_quo_nx;
                        r_cnt    <= r_cnt + c_CNT_ONE;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        r_result <= w_fix_res;
                        r_done   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_DONE;
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
